// File: rtl/write_back_queue_pkg.sv
// ============================================================================
// Module  : write_back_queue_pkg
// Brief   : Shared register-file types, special register indices and the
//           store-queue entry format for the write-back stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package write_back_queue_pkg;

    localparam int NR        = 16;
    localparam int REG_IDX_W = $clog2(NR);
    localparam int FLAG_W    = 4;

    typedef logic [31:0]           regval_t;
    typedef logic [REG_IDX_W-1:0]  regidx_t;
    typedef regval_t [NR-1:0]      regfile_t;

    localparam regidx_t  Flags       = regidx_t'(NR - 2);
    localparam regidx_t  PC          = regidx_t'(NR - 1);
    localparam regfile_t ZeroRegFile = '0;

    typedef struct packed {
        regval_t address;
        regval_t data;
    } store_entry_t;

    function automatic regfile_t subst_in(input regfile_t rf, input regidx_t idx,
                                          input regval_t value);
        regfile_t r;
        r      = rf;
        r[idx] = value;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/write_back_queue_if.sv
// ============================================================================
// Module  : i_execute_to_write
// Brief   : Execute-to-write-back bundle; hold flows back to the execute stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface i_execute_to_write import write_back_queue_pkg::*; ();

    logic                  is_valid;
    regidx_t               destination_register;
    regval_t               destination_value;
    logic                  has_upper_value;
    regval_t               upper_value;
    logic                  is_writing_memory;
    regval_t               adjustment_value;
    logic [FLAG_W-1:0]     flags;
    regval_t               pc;
    logic                  has_flushed;
    logic                  hold;

    modport write_out (
        output is_valid, destination_register, destination_value, has_upper_value,
               upper_value, is_writing_memory, adjustment_value, flags, pc, has_flushed,
        input  hold
    );

    modport write_in (
        input  is_valid, destination_register, destination_value, has_upper_value,
               upper_value, is_writing_memory, adjustment_value, flags, pc, has_flushed,
        output hold
    );

endinterface

`default_nettype wire

// File: rtl/write_back_queue_store_fifo.sv
// ============================================================================
// Module  : store_fifo
// Brief   : Power-of-two FIFO of committed stores awaiting memory acceptance.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module store_fifo import write_back_queue_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          push,
    input  store_entry_t                  push_entry,
    input  logic                          pop,
    output store_entry_t                  head_entry,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] C_FULL_COUNT = CNT_W'(DEPTH);

    store_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full  = (r_count == C_FULL_COUNT);
    assign empty = (r_count == '0);

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_entry;
        end
    end

    assign head_entry = r_mem[r_rd_ptr];
    assign count      = r_count;

endmodule

`default_nettype wire

// File: rtl/write_back_queue.sv
// ============================================================================
// Module  : write_back_queue
// Brief   : Write-back stage: register-file update plus an in-order queue of
//           committed stores drained to memory by a valid handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module write_back_queue import write_back_queue_pkg::*; #(
    parameter int DEPTH          = 4,
    parameter bit HAS_PAIR_WRITE = 1'b1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    i_execute_to_write.write_in           ini,
    input  regfile_t                      input_registers,
    input  regval_t                       next_pc,
    input  logic                          data_valid,
    output regval_t                       address,
    output regval_t                       data,
    output logic                          address_enable,
    output logic [$clog2(DEPTH+1)-1:0]    store_pending,
    output logic                          has_flushed,
    output regfile_t                      output_registers
);

    logic          w_is_store;
    logic          w_hold;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_pair_allowed;
    logic          w_pair_en;
    logic          w_flags_targeted;
    regidx_t       w_pair_idx;
    regval_t       w_merged_flags;
    store_entry_t  w_push_entry;
    store_entry_t  w_head_entry;
    regfile_t      w_next_regs;
    regfile_t      r_regs;
    logic          r_has_flushed;

    if (HAS_PAIR_WRITE) begin : g_pair_write
        assign w_pair_allowed = 1'b1;
    end else begin : g_no_pair_write
        assign w_pair_allowed = 1'b0;
    end

    assign w_is_store = ini.is_valid && ini.is_writing_memory;
    assign w_hold     = reset_n && w_is_store && w_full && !data_valid;
    assign ini.hold   = w_hold;
    assign w_push     = w_is_store && !w_hold;
    assign w_pop      = data_valid && !w_empty;

    assign w_push_entry.address = input_registers[ini.destination_register] + ini.adjustment_value;
    assign w_push_entry.data    = ini.destination_value;

    assign w_merged_flags = {input_registers[Flags][31], ini.flags, input_registers[Flags][26:0]};

    always_comb begin
        w_next_regs      = input_registers;
        w_pair_idx       = ini.destination_register + regidx_t'(1);
        // A pair write anchored on the zero register is discarded with it.
        w_pair_en        = w_pair_allowed && ini.has_upper_value
                           && (ini.destination_register != '0)
                           && ((int'(ini.destination_register) + 1) < NR);
        w_flags_targeted = (ini.destination_register == Flags)
                           || (w_pair_en && (w_pair_idx == Flags));

        if (!ini.is_valid) begin
            w_next_regs = subst_in(w_next_regs, PC, next_pc);
        end else begin
            if (!ini.is_writing_memory) begin
                w_next_regs = subst_in(w_next_regs, ini.destination_register,
                                       ini.destination_value);
                if (w_pair_en) begin
                    w_next_regs = subst_in(w_next_regs, w_pair_idx, ini.upper_value);
                end
            end
            if (ini.is_writing_memory || !w_flags_targeted) begin
                w_next_regs = subst_in(w_next_regs, Flags, w_merged_flags);
            end
            w_next_regs = subst_in(w_next_regs, PC,
                                   (!ini.is_writing_memory && (ini.destination_register == PC))
                                   ? ini.destination_value : next_pc);
        end
        w_next_regs = subst_in(w_next_regs, regidx_t'(0), '0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_regs        <= ZeroRegFile;
            r_has_flushed <= 1'b0;
        end else begin
            r_has_flushed <= ini.has_flushed;
            if (!w_hold) begin
                r_regs <= w_next_regs;
            end
        end
    end

    store_fifo #(
        .DEPTH (DEPTH)
    ) u_store_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .head_entry (w_head_entry),
        .full       (w_full),
        .empty      (w_empty),
        .count      (store_pending)
    );

    // Storage is not reset, so the bus is forced quiet while nothing is queued.
    assign address          = w_empty ? '0 : w_head_entry.address;
    assign data             = w_empty ? '0 : w_head_entry.data;
    assign address_enable   = !w_empty;
    assign has_flushed      = r_has_flushed;
    assign output_registers = r_regs;

endmodule

`default_nettype wire

// File: tb/tb_write_back_queue.sv
// ============================================================================
// Module  : tb_write_back_queue
// Brief   : Directed and randomized bench for write_back_queue against a
//           queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_write_back_queue;
    import write_back_queue_pkg::*;

    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset_n;
    regval_t    next_pc;
    logic       data_valid;
    regval_t    address;
    regval_t    data;
    logic       address_enable;
    logic [2:0] store_pending;
    logic       has_flushed;
    regfile_t   regs;

    logic        s_valid, s_mem, s_upper, s_flush;
    regidx_t     s_dest;
    regval_t     s_val, s_up, s_adj;
    logic [3:0]  s_flags;

    i_execute_to_write wb_if ();

    assign wb_if.is_valid             = s_valid;
    assign wb_if.destination_register = s_dest;
    assign wb_if.destination_value    = s_val;
    assign wb_if.has_upper_value      = s_upper;
    assign wb_if.upper_value          = s_up;
    assign wb_if.is_writing_memory    = s_mem;
    assign wb_if.adjustment_value     = s_adj;
    assign wb_if.flags                = s_flags;
    assign wb_if.pc                   = '0;
    assign wb_if.has_flushed          = s_flush;

    write_back_queue #(
        .DEPTH          (DEPTH),
        .HAS_PAIR_WRITE (1'b1)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .ini              (wb_if),
        .input_registers  (regs),
        .next_pc          (next_pc),
        .data_valid       (data_valid),
        .address          (address),
        .data             (data),
        .address_enable   (address_enable),
        .store_pending    (store_pending),
        .has_flushed      (has_flushed),
        .output_registers (regs)
    );

    always #5 clock = ~clock;

    regval_t       m_regs [NR];
    store_entry_t  m_q [$];
    logic          m_flushed;
    regval_t       seen [$];
    int            passed = 0;
    int            total  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_rf(input string tag, input regfile_t obs, input regfile_t exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic regfile_t model_rf();
        regfile_t r;
        for (int i = 0; i < NR; i++) r[i] = m_regs[i];
        return r;
    endfunction

    function automatic logic exp_hold();
        return reset_n && s_valid && s_mem && (m_q.size() == DEPTH) && !data_valid;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_q.delete();
        m_flushed = 1'b0;
    endtask

    // Reference behaviour applied once per rising edge.
    task automatic model_step();
        regval_t addr, old_flags;
        int      d;
        logic    pe;
        if (exp_hold()) begin
            m_flushed = s_flush;
            return;
        end
        d         = int'(s_dest);
        addr      = m_regs[d] + s_adj;
        old_flags = m_regs[Flags];
        pe        = 1'b0;
        if (!s_valid) begin
            m_regs[PC] = next_pc;
        end else begin
            if (!s_mem) begin
                m_regs[d] = s_val;
                pe = s_upper && (d != 0) && (d + 1 < NR);
                if (pe) m_regs[d+1] = s_up;
            end
            if (s_mem || ((d != int'(Flags)) && !(pe && (d + 1 == int'(Flags)))))
                m_regs[Flags] = {old_flags[31], s_flags, old_flags[26:0]};
            m_regs[PC] = (!s_mem && (d == int'(PC))) ? s_val : next_pc;
        end
        m_regs[0] = '0;
        if (data_valid && (m_q.size() > 0)) void'(m_q.pop_front());
        if (s_valid && s_mem) m_q.push_back({addr, s_val});
        m_flushed = s_flush;
    endtask

    task automatic check_outputs(input string tag);
        regval_t ea, ed;
        ea = '0;
        ed = '0;
        if (m_q.size() > 0) begin
            ea = m_q[0].address;
            ed = m_q[0].data;
        end
        chk_rf({tag, ".regs"}, regs, model_rf());
        chk({tag, ".pending"}, 64'(store_pending), 64'(m_q.size()));
        chk({tag, ".addr_en"}, 64'(address_enable), 64'(m_q.size() != 0));
        chk({tag, ".address"}, 64'(address), 64'(ea));
        chk({tag, ".data"}, 64'(data), 64'(ed));
        chk({tag, ".flushed"}, 64'(has_flushed), 64'(m_flushed));
    endtask

    task automatic drive(input logic v, input logic mem, input logic up, input regidx_t dest,
                         input regval_t val, input regval_t upv, input regval_t adj,
                         input logic [3:0] fl, input regval_t npc, input logic flush,
                         input logic dv);
        s_valid = v; s_mem = mem; s_upper = up; s_dest = dest;
        s_val = val; s_up = upv; s_adj = adj; s_flags = fl;
        next_pc = npc; s_flush = flush; data_valid = dv;
    endtask

    task automatic tick(input string tag);
        #1;
        chk({tag, ".hold"}, 64'(wb_if.hold), 64'(exp_hold()));
        model_step();
        @(posedge clock);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1, 1, 0, 4'd3, 32'h0, 32'h0, 32'h0, 4'h0, 32'h0, 1, 0);
        model_reset();
        #12;
        chk("rst.hold", 64'(wb_if.hold), 64'd0);
        check_outputs("rst");
        drive(0, 0, 0, 4'd0, 0, 0, 0, 4'h0, 32'h4, 0, 0);
        reset_n = 1'b1;
        tick("idle0");

        // Pair write
        drive(1, 0, 1, 4'd5, 32'h1234, 32'hABCD, 0, 4'h5, 32'h8, 0, 0);
        tick("pair");
        chk("pair.r5", 64'(regs[5]), 64'h1234);
        chk("pair.r6", 64'(regs[6]), 64'hABCD);
        chk("pair.en", 64'(address_enable), 64'd0);

        // Single store with delayed acceptance
        drive(1, 0, 0, 4'd3, 32'h1000, 0, 0, 4'h2, 32'hC, 0, 0);
        tick("r3");
        drive(1, 1, 0, 4'd3, 32'hDEAD, 0, 32'h8, 4'h3, 32'h10, 0, 0);
        tick("st1");
        chk("st1.address", 64'(address), 64'h1008);
        chk("st1.data", 64'(data), 64'hDEAD);
        chk("st1.en", 64'(address_enable), 64'd1);
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 4'd0, 0, 0, 0, 4'h0, 32'h14, 0, 0);
            tick("st1wait");
            chk("st1wait.address", 64'(address), 64'h1008);
        end
        drive(0, 0, 0, 4'd0, 0, 0, 0, 4'h0, 32'h18, 0, 1);
        tick("st1pop");
        chk("st1pop.pending", 64'(store_pending), 64'd0);

        // Fill to capacity, then a fifth store
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 4'd3, 32'hB000 + 32'(i), 0, 32'(4 * i), 4'h1, 32'h20, 0, 0);
            tick("fill");
        end
        chk("fill.pending", 64'(store_pending), 64'd4);
        drive(1, 1, 0, 4'd3, 32'hB004, 0, 32'h40, 4'h1, 32'h24, 0, 0);
        #1;
        chk("full.hold", 64'(wb_if.hold), 64'd1);
        data_valid = 1'b1;
        tick("full_pop");
        chk("full_pop.pending", 64'(store_pending), 64'd4);
        chk("full_pop.address", 64'(address), 64'h1004);

        // Drain, then A/B/C with acceptance every other cycle
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 4'd0, 0, 0, 0, 4'h0, 32'h28, 0, 1);
            tick("drain");
        end
        seen.delete();
        for (int i = 0; i < 7; i++) begin
            if (i < 3) drive(1, 1, 0, 4'd5, 32'hA + 32'(i), 0, 32'h10 * 32'(i + 1), 4'h6, 32'h2C, 0, (i % 2) == 0);
            else       drive(0, 0, 0, 4'd0, 0, 0, 0, 4'h0, 32'h2C, 0, (i % 2) == 0);
            #1;
            if (data_valid && address_enable) seen.push_back(address);
            tick("abc");
        end
        chk("abc.count", 64'(seen.size()), 64'd3);
        if (seen.size() == 3) begin
            chk("abc.first", 64'(seen[0]), 64'h1244);
            chk("abc.second", 64'(seen[1]), 64'h1254);
            chk("abc.third", 64'(seen[2]), 64'h1264);
        end

        // Reset while draining
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 4'd3, 32'hC000 + 32'(i), 0, 32'(i), 4'h7, 32'h30, 1, 0);
            tick("pre_rst");
        end
        chk("pre_rst.pending", 64'(store_pending), 64'd3);
        drive(1, 1, 0, 4'd3, 32'hC003, 0, 0, 4'h7, 32'h34, 1, 1);
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst.hold", 64'(wb_if.hold), 64'd0);
        check_outputs("mid_rst");
        @(posedge clock);
        #3;
        drive(0, 0, 0, 4'd0, 0, 0, 0, 4'h0, 32'h38, 0, 1);
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick("post_rst");
            chk("post_rst.en", 64'(address_enable), 64'd0);
        end

        // PC handling
        drive(0, 0, 0, 4'd0, 0, 0, 0, 4'h0, 32'h40, 0, 0);
        tick("pc_seq");
        chk("pc_seq.pc", 64'(regs[PC]), 64'h40);
        drive(1, 0, 0, PC, 32'h80, 0, 0, 4'h9, 32'h44, 0, 0);
        tick("pc_br");
        chk("pc_br.pc", 64'(regs[PC]), 64'h80);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic    v, mem, up;
            regidx_t d;
            v   = ($urandom_range(0, 9) < 7);
            mem = ($urandom_range(0, 9) < 4);
            d   = regidx_t'($urandom_range(0, NR - 1));
            up  = (d != 0) && $urandom_range(0, 1) == 1;
            drive(v, mem, up, d, $urandom, $urandom, $urandom, 4'($urandom),
                  $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
            tick("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/write_back_queue.md
WRITE_BACK_QUEUE -- requirements
Module: write_back_queue

Interface
REQ-001 Parameter: DEPTH, default 4, store-queue entries; power of two, 2..16.
REQ-002 Parameter: HAS_PAIR_WRITE, default 1, enables upper_value write to destination_register+1.
REQ-003 Port: clock  input  1  single clock; all state on posedge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: ini  modport i_execute_to_write.write_in  --  execute-stage bundle (is_valid, destination_register, destination_value, has_upper_value, upper_value, is_writing_memory, adjustment_value, flags, pc, has_flushed, hold).
REQ-006 Port: input_registers  input  regfile_t  current architectural registers.
REQ-007 Port: next_pc  input  regval_t  PC when no branch writes PC.
REQ-008 Port: data_valid  input  1  memory accepted the presented store this cycle.
REQ-009 Port: address, data  output  regval_t each  head-of-queue store address and data.
REQ-010 Port: address_enable  output  1  store presented (queue non-empty).
REQ-011 Port: store_pending  output  $clog2(DEPTH+1)  queued store count, for load-hazard stalling.
REQ-012 Port: has_flushed  output  1  ini.has_flushed delayed one cycle.
REQ-013 Port: output_registers  output  regfile_t  next architectural registers.

Function
REQ-014 Register 0 SHALL always write 0.
REQ-015 Valid non-store: destination_register SHALL take destination_value; if HAS_PAIR_WRITE and has_upper_value and destination_register+1 < NR, that register SHALL take upper_value; pair write to register 0 SHALL be ignored.
REQ-016 Flags register, when not a destination, SHALL take {bit31 unchanged, ini.flags, bits 26:0 unchanged}.
REQ-017 PC SHALL take destination_value if valid non-store destination is PC, else next_pc.
REQ-018 Invalid cycle: only PC SHALL update; all other output_registers hold.
REQ-019 Valid store: no general register written (flags and PC still update); entry {registers[destination_register]+adjustment_value modulo 2^32, destination_value} SHALL be pushed.
REQ-020 Push SHALL be accepted when store_pending < DEPTH, or when full and data_valid pops the head the same cycle.
REQ-021 ini.hold SHALL be 1 iff reset_n, valid store, queue full and !data_valid; while held no register update or push occurs (PC included).
REQ-022 Pushed entry SHALL appear on address/data one cycle after acceptance when queue was empty; order strictly FIFO.
REQ-023 address_enable = (store_pending != 0); address/data SHALL hold stable until data_valid.
REQ-024 data_valid with address_enable low SHALL be ignored.
REQ-025 Simultaneous push and pop SHALL leave store_pending unchanged; pointers wrap modulo DEPTH.
REQ-026 ini.has_flushed SHALL NOT discard queued stores (already committed).

Reset
REQ-027 On reset_n low, immediately: output_registers = ZeroRegFile, has_flushed = 0, store_pending = 0, pointers = 0, address_enable = 0, ini.hold = 0.
REQ-028 Reset mid-drain SHALL abandon the presented store; no entry survives reset.

Structure
REQ-029 regval_t, regfile_t, NR, Flags, PC, ZeroRegFile, subst_in and new store_entry_t {address, data} SHALL live in the shared package.
REQ-030 Queue SHALL be sub-module store_fifo (parameter DEPTH, push/pop/full/empty/count, async active-low reset).

Verification
REQ-031 Valid non-store dest=5 value 0x1234, has_upper_value, upper 0xABCD -> next cycle r5=0x1234, r6=0xABCD, address_enable=0.
REQ-032 Store r3=0x1000 adj 8 data 0xDEAD, data_valid low -> next cycle address=0x1008, data=0xDEAD, address_enable=1, held until data_valid; then store_pending=0.
REQ-033 DEPTH=4, five consecutive stores, data_valid low -> store_pending=4, hold=1 on fifth; data_valid pulse same cycle -> fifth accepted, count stays 4.
REQ-034 Stores A,B,C with data_valid every other cycle -> bus shows A,B,C in order, each stable until accepted.
REQ-035 reset_n low while store_pending=3 and address_enable=1 -> all outputs zero immediately; no store after release.
REQ-036 Invalid cycle with next_pc=0x40 -> only PC=0x40 changes; dest=PC branch 0x80 -> PC=0x80.
